// File: rtl/alu_exec_unit.sv
// Multi-cycle execute stage: single-cycle ALU ops, or a 16-iteration shift-add multiply.
// Done one edge after accept (16 edges for MUL); start is ignored while busy, with no queuing.
module alu_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  opcode,
  input  logic [15:0] opa1,
  input  logic [15:0] opa2,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] MULT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [3:0]  cnt;
  logic [31:0] acc, mcand, acc_nxt;
  logic [15:0] mplier;

  logic [16:0] sum17, dif17, shl17, shr17;
  logic [15:0] alu_val;
  logic        alu_c, alu_v, legal, wr_res;

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign acc_nxt = mplier[0] ? acc + mcand : acc;

  always_comb begin
    sum17   = {1'b0, a_q} + {1'b0, b_q};
    dif17   = {1'b0, a_q} + {1'b0, ~b_q} + 17'd1;
    // Extra bit on the outgoing side captures the last bit shifted out.
    shl17   = {1'b0, a_q} << b_q[3:0];
    shr17   = {a_q, 1'b0} >> b_q[3:0];
    alu_val = a_q;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    legal   = 1'b1;
    wr_res  = 1'b1;
    case (op_q)
      4'd0: begin
        alu_val = sum17[15:0];
        alu_c   = sum17[16];
        alu_v   = (a_q[15] == b_q[15]) && (sum17[15] != a_q[15]);
      end
      4'd1, 4'd9: begin
        alu_val = dif17[15:0];
        alu_c   = dif17[16];
        alu_v   = (a_q[15] != b_q[15]) && (dif17[15] != a_q[15]);
        wr_res  = (op_q == 4'd1);
      end
      4'd2: alu_val = a_q & b_q;
      4'd3: alu_val = a_q | b_q;
      4'd4: alu_val = a_q ^ b_q;
      4'd5: alu_val = ~a_q;
      4'd6: begin
        alu_val = shl17[15:0];
        alu_c   = shl17[16];
      end
      4'd7: begin
        alu_val = shr17[16:1];
        alu_c   = shr17[0];
      end
      default: begin
        legal  = 1'b0;
        wr_res = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      op_q   <= 4'd0;
      a_q    <= 16'd0;
      b_q    <= 16'd0;
      cnt    <= 4'd0;
      acc    <= 32'd0;
      mcand  <= 32'd0;
      mplier <= 16'd0;
      result <= 16'd0;
      flags  <= 4'd0;
      err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q   <= opcode;
          a_q    <= opa1;
          b_q    <= opa2;
          err    <= 1'b0;
          cnt    <= 4'd0;
          acc    <= 32'd0;
          mcand  <= {16'd0, opa1};
          mplier <= opa2;
          state  <= (opcode == 4'd8) ? MULT : EXEC;
        end
        EXEC: begin
          if (legal) flags <= {alu_val == 16'd0, alu_val[15], alu_c, alu_v};
          else       err   <= 1'b1;
          if (wr_res) result <= alu_val;
          state <= DONE;
        end
        MULT: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            result <= acc_nxt[15:0];
            flags  <= {acc_nxt[15:0] == 16'd0, acc_nxt[15], |acc_nxt[31:16], 1'b0};
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
